// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
// Group width, op encodings and the stage-count helper.
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int n_groups(input int width);
        return width / GROUP_W;
    endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand-side and result-side valid/ready bundle.
// The adder is the slave; the producer/consumer pair is the master.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_result,
        output out_carry, out_ovf, out_zero
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_carry, out_ovf, out_zero
    );
endinterface

// File: rtl/cla4_group.sv
// Combinational 4-bit carry-lookahead group.
// Produces sum, carry-out, carry into bit 3 and group P/G.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a_i,
    input  logic [GROUP_W-1:0] b_i,
    input  logic               cin_i,
    output logic [GROUP_W-1:0] s_o,
    output logic               cout_o,
    output logic               c3_o,
    output logic               p_o,
    output logic               g_o
);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    assign c1 = g[0] | (p[0] & cin_i);
    assign c2 = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin_i);
    assign c3_o = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);

    assign g_o = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    assign p_o = &p;

    assign cout_o = g_o | (p_o & cin_i);
    assign s_o    = p ^ {c3_o, c2, c1, cin_i};
endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA adder/subtractor, one 4-bit group per stage.
// Operands skew forward, sums accumulate; a single advance stalls all.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    cla_pipe_addsub_if.slave bus
);
    localparam int N = n_groups(WIDTH);

    if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
        $error("cla_pipe_addsub: WIDTH must be a positive multiple of 4");
    end

    logic             adv;
    logic             sub;
    logic [WIDTH-1:0] b_acc;
    logic             c_acc;

    // Subtract becomes a + ~b + ~cin right at the input.
    assign sub   = (bus.in_op == OP_SUB);
    assign b_acc = sub ? ~bus.in_b : bus.in_b;
    assign c_acc = bus.in_cin ^ sub;

    for (genvar k = 0; k < N; k++) begin : g_st
        logic [WIDTH-1:GROUP_W*k]     a_rem;
        logic [WIDTH-1:GROUP_W*k]     b_rem;
        logic [GROUP_W-1:0]           s4;
        logic [GROUP_W*(k+1)-1:0]     s_d;
        logic [GROUP_W*(k+1)-1:0]     s_q;
        logic                         c_in;
        logic                         z_in;
        logic                         z_d;
        logic                         v_in;
        logic                         co;
        logic                         c3;
        logic                         gp;
        logic                         gg;
        logic                         c_q;
        logic                         z_q;
        logic                         v_q;

        if (k == 0) begin : g_src
            assign a_rem = bus.in_a;
            assign b_rem = b_acc;
            assign c_in  = c_acc;
            assign z_in  = 1'b1;
            assign v_in  = bus.in_valid;
            assign s_d   = s4;
        end else begin : g_src
            assign a_rem = g_st[k-1].g_ops.a_q;
            assign b_rem = g_st[k-1].g_ops.b_q;
            assign c_in  = g_st[k-1].c_q;
            assign z_in  = g_st[k-1].z_q;
            assign v_in  = g_st[k-1].v_q;
            assign s_d   = {s4, g_st[k-1].s_q};
        end

        cla4_group u_grp (
            .a_i    (a_rem[GROUP_W*k +: GROUP_W]),
            .b_i    (b_rem[GROUP_W*k +: GROUP_W]),
            .cin_i  (c_in),
            .s_o    (s4),
            .cout_o (co),
            .c3_o   (c3),
            .p_o    (gp),
            .g_o    (gg)
        );

        assign z_d = z_in & (s4 == '0);

        // Group outputs must agree with their own P/G and bit-3 carry.
        always_comb begin : a_grp
            assert (co == (gg | (gp & c_in)));
            assert (s4[GROUP_W-1] ==
                    (a_rem[GROUP_W*k+3] ^ b_rem[GROUP_W*k+3] ^ c3));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s_q <= '0;
                c_q <= 1'b0;
                z_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= co;
                z_q <= z_d;
                v_q <= v_in;
            end
        end

        if (k < N-1) begin : g_ops
            logic [WIDTH-1:GROUP_W*(k+1)] a_q;
            logic [WIDTH-1:GROUP_W*(k+1)] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_rem[WIDTH-1:GROUP_W*(k+1)];
                    b_q <= b_rem[WIDTH-1:GROUP_W*(k+1)];
                end
            end
        end

        if (k == N-1) begin : g_fl
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c3 ^ co;
                end
            end
        end
    end

    assign adv = ~g_st[N-1].v_q | bus.out_ready;

    assign bus.in_ready   = adv;
    assign bus.out_valid  = g_st[N-1].v_q;
    assign bus.out_result = g_st[N-1].s_q;
    assign bus.out_carry  = g_st[N-1].c_q;
    assign bus.out_ovf    = g_st[N-1].g_fl.ovf_q;
    assign bus.out_zero   = g_st[N-1].z_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub at WIDTH 16, 4 and 32 sharing one stimulus.
// Arithmetic reference model plus hand-computed corner vectors.
module tb_cla_pipe_addsub;
    import cla_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_op = 1'b0;
    logic        s_cin = 1'b0;
    logic        s_ordy = 1'b1;
    logic [31:0] s_a = '0;
    logic [31:0] s_b = '0;

    always #5 clk = ~clk;

    cla_pipe_addsub_if #(.WIDTH(16)) b16 ();
    cla_pipe_addsub_if #(.WIDTH(4))  b4 ();
    cla_pipe_addsub_if #(.WIDTH(32)) b32 ();

    assign b16.in_valid = s_valid;
    assign b16.in_op    = s_op;
    assign b16.in_a     = s_a[15:0];
    assign b16.in_b     = s_b[15:0];
    assign b16.in_cin   = s_cin;
    assign b16.out_ready = s_ordy;

    assign b4.in_valid = s_valid;
    assign b4.in_op    = s_op;
    assign b4.in_a     = s_a[3:0];
    assign b4.in_b     = s_b[3:0];
    assign b4.in_cin   = s_cin;
    assign b4.out_ready = s_ordy;

    assign b32.in_valid = s_valid;
    assign b32.in_op    = s_op;
    assign b32.in_a     = s_a;
    assign b32.in_b     = s_b;
    assign b32.in_cin   = s_cin;
    assign b32.out_ready = s_ordy;

    cla_pipe_addsub #(.WIDTH(16)) u_w16 (
        .clk(clk), .reset(rst), .bus(b16.slave));
    cla_pipe_addsub #(.WIDTH(4)) u_w4 (
        .clk(clk), .reset(rst), .bus(b4.slave));
    cla_pipe_addsub #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset(rst), .bus(b32.slave));

    logic        ir [3];
    logic        ov [3];
    logic        oc [3];
    logic        oo [3];
    logic        oz [3];
    logic [31:0] res [3];

    assign ir[0] = b16.in_ready;
    assign ov[0] = b16.out_valid;
    assign oc[0] = b16.out_carry;
    assign oo[0] = b16.out_ovf;
    assign oz[0] = b16.out_zero;
    assign res[0] = {16'h0, b16.out_result};
    assign ir[1] = b4.in_ready;
    assign ov[1] = b4.out_valid;
    assign oc[1] = b4.out_carry;
    assign oo[1] = b4.out_ovf;
    assign oz[1] = b4.out_zero;
    assign res[1] = {28'h0, b4.out_result};
    assign ir[2] = b32.in_ready;
    assign ov[2] = b32.out_valid;
    assign oc[2] = b32.out_carry;
    assign oo[2] = b32.out_ovf;
    assign oz[2] = b32.out_zero;
    assign res[2] = b32.out_result;

    int    W   [3] = '{16, 4, 32};
    int    LAT [3] = '{4, 1, 8};
    string NM  [3] = '{"w16", "w4", "w32"};

    int n_checks = 0;
    int n_err = 0;

    exp_t q [3][$];
    exp_t held [3];
    logic stall_p [3] = '{1'b0, 1'b0, 1'b0};
    logic rst_p   [3] = '{1'b0, 1'b0, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain modular and signed arithmetic on the true values.
    function automatic exp_t model(input int w, input logic op,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic cin);
        longint m, half, ua, ub, sa, sb, ci, full, tr;
        exp_t   e;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        ci   = cin ? 64'sd1 : 64'sd0;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        if (op == OP_ADD) begin
            full = ua + ub + ci;
            tr   = sa + sb + ci;
            e.c  = ((full >> w) & 1) != 0;
        end else begin
            full = ua - ub - ci;
            tr   = sa - sb - ci;
            e.c  = (full >= 0);
        end
        e.r = 32'(full & m);
        e.o = (tr >= half) || (tr < -half);
        e.z = ((full & m) == 0);
        return e;
    endfunction

    task automatic mon(input int i);
        exp_t act;
        exp_t e;
        act = '{r: res[i], c: oc[i], o: oo[i], z: oz[i]};
        if (rst_p[i]) begin
            chk({NM[i], "_rst_flags"},
                {28'h0, ov[i], oc[i], oo[i], oz[i]}, 32'h0);
            chk({NM[i], "_rst_result"}, res[i], 32'h0);
        end
        chk({NM[i], "_in_ready"}, {31'h0, ir[i]},
            {31'h0, ~ov[i] | s_ordy});
        if (stall_p[i]) begin
            chk({NM[i], "_stall_result"}, res[i], held[i].r);
            chk({NM[i], "_stall_flags"},
                {28'h0, ov[i], oc[i], oo[i], oz[i]},
                {28'h0, 1'b1, held[i].c, held[i].o, held[i].z});
        end
        if (ov[i] && s_ordy) begin
            if (q[i].size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL %s_unexpected: got result %h expected none",
                         NM[i], res[i]);
            end else begin
                e = q[i].pop_front();
                chk({NM[i], "_result"}, res[i], e.r);
                chk({NM[i], "_flags"}, {29'h0, oc[i], oo[i], oz[i]},
                    {29'h0, e.c, e.o, e.z});
            end
        end
        if (s_valid && ir[i] && !rst)
            q[i].push_back(model(W[i], s_op, s_a, s_b, s_cin));
        if (rst)
            q[i].delete();
        stall_p[i] = ov[i] & ~s_ordy & ~rst;
        held[i]    = act;
        rst_p[i]   = rst;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) mon(i);
    end

    task automatic dir(input int i, input logic op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [31:0] er,
                       input logic ec, input logic eo, input logic ez);
        int   cnt;
        exp_t m;
        m = model(W[i], op, a, b, cin);
        chk({NM[i], "_model_pin"}, m.r, er);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_op    = op;
        s_a     = a;
        s_b     = b;
        s_cin   = cin;
        s_ordy  = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1;
            s_valid = 1'b0;
        end while (!ov[i] && cnt < 20);
        chk({NM[i], "_latency"}, cnt, LAT[i]);
        chk({NM[i], "_dir_result"}, res[i], er);
        chk({NM[i], "_dir_flags"}, {29'h0, oc[i], oo[i], oz[i]},
            {29'h0, ec, eo, ez});
        repeat (10) @(posedge clk);
    endtask

    task automatic drive_rand(input logic vld);
        s_valid = vld;
        s_op    = 1'($urandom_range(0, 1));
        s_a     = $urandom;
        s_b     = $urandom;
        s_cin   = 1'($urandom_range(0, 1));
        s_ordy  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("w16_reset_valid", {31'h0, ov[0]}, 32'h0);
        chk("w16_reset_ready", {31'h0, ir[0]}, 32'h1);

        dir(0, OP_ADD, 32'h1234, 32'h0FFF, 1'b0, 32'h2233, 0, 0, 0);
        dir(0, OP_ADD, 32'hFFFF, 32'h0001, 1'b0, 32'h0000, 1, 0, 1);
        dir(0, OP_ADD, 32'h7FFF, 32'h0001, 1'b0, 32'h8000, 0, 1, 0);
        dir(0, OP_SUB, 32'h0005, 32'h0007, 1'b0, 32'hFFFE, 0, 0, 0);
        dir(0, OP_SUB, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1, 1, 0);
        dir(0, OP_SUB, 32'h0010, 32'h000F, 1'b1, 32'h0000, 1, 0, 1);

        dir(1, OP_ADD, 32'hF, 32'h1, 1'b0, 32'h0, 1, 0, 1);
        dir(1, OP_ADD, 32'h7, 32'h1, 1'b0, 32'h8, 0, 1, 0);
        dir(1, OP_SUB, 32'h5, 32'h7, 1'b0, 32'hE, 0, 0, 0);
        dir(1, OP_SUB, 32'h8, 32'h1, 1'b0, 32'h7, 1, 1, 0);

        dir(2, OP_ADD, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1, 0, 1);
        dir(2, OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 0, 1, 0);
        dir(2, OP_SUB, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1, 1, 0);
        dir(2, OP_SUB, 32'h5, 32'h7, 1'b0, 32'hFFFFFFFE, 0, 0, 0);

        // Back-to-back ops under a toggling consumer.
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 200) begin
            @(posedge clk);
            #1;
            drive_rand(1'b1);
            #1;
            if (s_valid && ir[0]) acc++;
            cyc++;
        end
        chk("w16_bp_accepts", acc, 8);

        for (int n = 0; n < 150; n++) begin
            @(posedge clk);
            #1;
            drive_rand($urandom_range(0, 3) != 0);
        end

        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_ordy  = 1'b1;
        repeat (20) @(posedge clk);

        // Three ops in flight, then a reset cycle that also offers an op.
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            s_valid = 1'b1;
            s_op    = OP_ADD;
            s_a     = 32'h1111 * (n + 1);
            s_b     = 32'h0101;
            s_cin   = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_a = 32'hABCD;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        repeat (15) @(posedge clk);

        dir(0, OP_ADD, 32'h0001, 32'h0002, 1'b1, 32'h0004, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk({NM[i], "_drained"}, q[i].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
